// File: rtl/interconexion_pio_arbiter.sv
// Round-robin arbiter: two byte requesters share one Avalon-MM PIO slave.
// Optional readback check is compiled in with `define PIO_ARB_READBACK_EN.
module interconexion_pio_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [7:0]  data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [7:0]  data1,
    output logic        ack1,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
`ifdef PIO_ARB_READBACK_EN
        READ  = 2'd3,
`endif
        ACK   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q,  last_d;
    logic [7:0] byte_q,  byte_d;
    logic       pick;

    // Tie goes to whoever was not served last; a lone request wins outright.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_q;
        end else begin
            pick = req1;
        end
    end

    // State, grant and byte registers; reset leaves requester 1 as last served.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
        end
    end

    // Next-state logic; the byte is captured only at the moment of grant.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        byte_d  = byte_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = pick;
                    byte_d  = pick ? data1 : data0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
`ifdef PIO_ARB_READBACK_EN
                state_d = READ;
`else
                state_d = ACK;
`endif
            end
`ifdef PIO_ARB_READBACK_EN
            READ: begin
                state_d = ACK;
            end
`endif
            ACK: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus strobes and handshakes decoded straight from the current state.
    always_comb begin
        avm_address    = 2'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 32'h0;
        ack0           = 1'b0;
        ack1           = 1'b0;
        busy           = (state_q != IDLE);
        if (state_q == WRITE) begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_writedata  = {24'h0, byte_q};
        end
`ifdef PIO_ARB_READBACK_EN
        if (state_q == READ) begin
            avm_chipselect = 1'b1;
        end
`endif
        if (state_q == ACK) begin
            ack0 = ~grant_q;
            ack1 = grant_q;
        end
    end

    // Only the low byte of readdata is meaningful for this PIO.
    logic unused_rd;
    assign unused_rd = ^avm_readdata[31:8];

`ifdef PIO_ARB_READBACK_EN
    logic err_q, err_d;

    // Sticky mismatch flag: readback byte differs from what was written.
    always_comb begin
        err_d = err_q;
        if (state_q == READ && avm_readdata[7:0] != byte_q) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_lo;
    assign unused_lo = ^avm_readdata[7:0];
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_interconexion_pio_arbiter.sv
// Directed bench for the two-requester PIO arbiter.
// Latency expectations follow PIO_ARB_READBACK_EN.
module tb_interconexion_pio_arbiter;

`ifdef PIO_ARB_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int LACK = 1 + RB;
    localparam int PER  = 3 + RB;

    logic        clk;
    logic        reset_n;
    logic        req0, req1;
    logic [7:0]  data0, data1;
    logic        ack0, ack1;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        busy, err;

    logic [31:0] pio_q;
    logic        pio_bad;

    int vectors;
    int miscompares;

    interconexion_pio_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req0           (req0),
        .data0          (data0),
        .ack0           (ack0),
        .req1           (req1),
        .data1          (data1),
        .ack1           (ack1),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n)
            pio_q <= 32'h0;
        else if (avm_chipselect && !avm_write_n)
            pio_q <= avm_writedata;
    end
    assign avm_readdata = pio_bad ? 32'h0 : pio_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(output logic [31:0] wd, output int cyc);
        bit found;
        found = 0;
        cyc = -1;
        wd = 32'h0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (avm_chipselect && !avm_write_n) begin
                wd = avm_writedata;
                cyc = i;
                found = 1;
            end
        end
    endtask

    task automatic wait_ack(output logic a0, output logic a1, output int cyc);
        bit found;
        found = 0;
        cyc = -1;
        a0 = 1'b0;
        a1 = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (ack0 || ack1) begin
                a0 = ack0;
                a1 = ack1;
                cyc = i;
                found = 1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        vectors++;
        if ({ack0, ack1} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ack got %b want 00", {ack0, ack1});
        end
        vectors++;
        if ({avm_chipselect, avm_write_n} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_strobes got %b want 01",
                     {avm_chipselect, avm_write_n});
        end
        vectors++;
        if (avm_writedata !== 32'h0 || avm_address !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_bus got %h/%0d want 0/0",
                     avm_writedata, avm_address);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err got %b want 0", err);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (busy !== 1'b0 || avm_chipselect !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_noreq got busy=%b cs=%b want 0 0",
                     busy, avm_chipselect);
        end
    endtask

    task automatic test_single();
        logic [31:0] wd;
        logic a0, a1;
        int c;
        req0 = 1'b1;
        data0 = 8'hA5;
        wait_write(wd, c);
        vectors++;
        if (c !== 0) begin
            miscompares++;
            $display("FAIL single_wr_lat got %0d want 0", c);
        end
        vectors++;
        if (wd !== 32'h000000A5 || avm_address !== 2'd0) begin
            miscompares++;
            $display("FAIL single_wdata got %h/%0d want 000000a5/0",
                     wd, avm_address);
        end
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy got %b want 1", busy);
        end
        wait_ack(a0, a1, c);
        req0 = 1'b0;
        vectors++;
        if (c !== LACK - 1) begin
            miscompares++;
            $display("FAIL single_ack_lat got %0d want %0d", c, LACK - 1);
        end
        vectors++;
        if ({a0, a1} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_ack got %b want 10", {a0, a1});
        end
        step();
        vectors++;
        if (busy !== 1'b0 || ack0 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end got busy=%b ack0=%b want 0 0",
                     busy, ack0);
        end
    endtask

    task automatic test_tie();
        logic [31:0] wd;
        logic a0, a1;
        int c;
        logic [7:0] exp_d [3];
        logic       exp_g [3];
        exp_d[0] = 8'h11; exp_g[0] = 1'b0;
        exp_d[1] = 8'h22; exp_g[1] = 1'b1;
        exp_d[2] = 8'h11; exp_g[2] = 1'b0;
        do_reset();
        req0 = 1'b1; data0 = 8'h11;
        req1 = 1'b1; data1 = 8'h22;
        for (int k = 0; k < 3; k++) begin
            wait_write(wd, c);
            vectors++;
            if (wd !== {24'h0, exp_d[k]}) begin
                miscompares++;
                $display("FAIL tie_wdata[%0d] got %h want %h",
                         k, wd, exp_d[k]);
            end
            wait_ack(a0, a1, c);
            vectors++;
            if ({a0, a1} !== {~exp_g[k], exp_g[k]}) begin
                miscompares++;
                $display("FAIL tie_ack[%0d] got %b want %b",
                         k, {a0, a1}, {~exp_g[k], exp_g[k]});
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
    endtask

    task automatic test_data_change();
        logic [31:0] wd;
        logic a0, a1;
        int c;
        req0 = 1'b1;
        data0 = 8'h3C;
        wait_write(wd, c);
        data0 = 8'hFF;
        #1;
        vectors++;
        if (avm_writedata !== 32'h0000003C) begin
            miscompares++;
            $display("FAIL data_change got %h want 0000003c", avm_writedata);
        end
        wait_ack(a0, a1, c);
        req0 = 1'b0;
        vectors++;
        if (pio_q !== 32'h0000003C) begin
            miscompares++;
            $display("FAIL data_change_pio got %h want 0000003c", pio_q);
        end
        step();
    endtask

    task automatic test_drop_and_wait();
        logic [31:0] wd;
        logic a0, a1;
        int c;
        req0 = 1'b1;
        data0 = 8'h42;
        wait_write(wd, c);
        req0 = 1'b0;
        req1 = 1'b1;
        data1 = 8'h6B;
        wait_ack(a0, a1, c);
        vectors++;
        if ({a0, a1} !== 2'b10) begin
            miscompares++;
            $display("FAIL drop_ack got %b want 10", {a0, a1});
        end
        wait_write(wd, c);
        vectors++;
        if (wd !== 32'h0000006B || c !== 1) begin
            miscompares++;
            $display("FAIL wait_grant got %h@%0d want 0000006b@1", wd, c);
        end
        wait_ack(a0, a1, c);
        req1 = 1'b0;
        vectors++;
        if ({a0, a1} !== 2'b01) begin
            miscompares++;
            $display("FAIL wait_ack got %b want 01", {a0, a1});
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd;
        logic a0, a1;
        int c;
        req1 = 1'b1;
        data1 = 8'h99;
        wait_write(wd, c);
        reset_n = 1'b0;
        step();
        vectors++;
        if ({avm_chipselect, avm_write_n, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL rst_mid_bus got %b want 010",
                     {avm_chipselect, avm_write_n, busy});
        end
        step();
        vectors++;
        if ({ack0, ack1} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_ack got %b want 00", {ack0, ack1});
        end
        data1 = 8'h77;
        reset_n = 1'b1;
        wait_write(wd, c);
        vectors++;
        if (wd !== 32'h00000077 || c !== 0) begin
            miscompares++;
            $display("FAIL rst_after_wr got %h@%0d want 00000077@0", wd, c);
        end
        wait_ack(a0, a1, c);
        req1 = 1'b0;
        vectors++;
        if ({a0, a1} !== 2'b01 || c !== LACK - 1) begin
            miscompares++;
            $display("FAIL rst_after_ack got %b@%0d want 01@%0d",
                     {a0, a1}, c, LACK - 1);
        end
        step();
    endtask

`ifdef PIO_ARB_READBACK_EN
    task automatic test_readback();
        logic [31:0] wd;
        logic a0, a1;
        int c;
        do_reset();
        pio_bad = 1'b1;
        req0 = 1'b1;
        data0 = 8'h5A;
        wait_write(wd, c);
        wait_ack(a0, a1, c);
        req0 = 1'b0;
        vectors++;
        if ({a0, a1, err} !== 3'b101) begin
            miscompares++;
            $display("FAIL rb_bad got ack=%b err=%b want 10 1", {a0, a1}, err);
        end
        step();
        pio_bad = 1'b0;
        req1 = 1'b1;
        data1 = 8'h33;
        wait_write(wd, c);
        wait_ack(a0, a1, c);
        req1 = 1'b0;
        vectors++;
        if ({a0, a1, err} !== 3'b011) begin
            miscompares++;
            $display("FAIL rb_sticky got ack=%b err=%b want 01 1",
                     {a0, a1}, err);
        end
        do_reset();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL rb_clear got %b want 0", err);
        end
    endtask
`else
    task automatic test_err_tied();
        logic [31:0] wd;
        logic a0, a1;
        int c;
        pio_bad = 1'b1;
        req0 = 1'b1;
        data0 = 8'h5A;
        wait_write(wd, c);
        wait_ack(a0, a1, c);
        req0 = 1'b0;
        vectors++;
        if ({a0, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL err_tied got ack0=%b err=%b want 1 0", a0, err);
        end
        pio_bad = 1'b0;
        step();
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] wd;
        int c;
        int writes, acks, a0n, both, last_w;
        req1 = 1'b1;
        data1 = 8'h5C;
        wait_write(wd, c);
        writes = 1;
        acks = 0;
        a0n = 0;
        both = 0;
        last_w = 0;
        for (int i = 1; i < 3 * PER; i++) begin
            step();
            if (avm_chipselect && !avm_write_n) begin
                vectors++;
                if (i - last_w !== PER) begin
                    miscompares++;
                    $display("FAIL b2b_gap got %0d want %0d", i - last_w, PER);
                end
                last_w = i;
                writes++;
            end
            if (ack1) acks++;
            if (ack0) a0n++;
            if (ack0 && ack1) both++;
        end
        req1 = 1'b0;
        vectors++;
        if (writes !== 3 || acks !== 3) begin
            miscompares++;
            $display("FAIL b2b_count got w=%0d a=%0d want 3 3", writes, acks);
        end
        vectors++;
        if (a0n !== 0 || both !== 0) begin
            miscompares++;
            $display("FAIL b2b_ack0 got a0=%0d both=%0d want 0 0", a0n, both);
        end
        repeat (2) step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        pio_bad = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_data_change();
        test_drop_and_wait();
        test_reset_mid();
`ifdef PIO_ARB_READBACK_EN
        test_readback();
`else
        test_err_tied();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
